// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared sizes, types and address-map helpers for the register file
package reg_file_pkg;
  localparam int REG_SIZE = 8;
  localparam int REG_QTY = 4;
  localparam int SEL_BITS = 4;
  localparam int VEC_SIZE = 4;
  localparam int IDX_BITS = $clog2(REG_QTY);
  typedef logic [REG_SIZE-1:0] lane_t;
  typedef lane_t [VEC_SIZE-1:0] vec_t;
  typedef logic [SEL_BITS-1:0] sel_t;
  typedef logic [IDX_BITS-1:0] idx_t;
  localparam sel_t VEC_BASE = '0;
  localparam sel_t SC_BASE = sel_t'(REG_QTY);
  localparam sel_t SPECIAL_BASE = sel_t'(2 * REG_QTY);
  typedef enum logic [1:0] {REGION_VEC, REGION_SC, REGION_SPECIAL} region_e;
  function automatic region_e region_of(sel_t a);
    return a < SC_BASE ? REGION_VEC : a < SPECIAL_BASE ? REGION_SC : REGION_SPECIAL;
  endfunction
endpackage

// File: rtl/reg_file_if.sv
// reg_file_if: read/write bus between the datapath and the register file
interface reg_file_if;
  import reg_file_pkg::*;
  logic regWrEnSc;
  logic regWrEnVec;
  sel_t rSel1;
  sel_t rSel2;
  sel_t regToWrite;
  vec_t dataIn;
  vec_t operand1;
  vec_t operand2;
  modport master (output regWrEnSc, regWrEnVec, rSel1, rSel2, regToWrite, dataIn, input operand1, operand2);
  modport slave (input regWrEnSc, regWrEnVec, rSel1, rSel2, regToWrite, dataIn, output operand1, operand2);
endinterface

// File: rtl/reg_file_read_port.sv
// reg_file_read_port: address decode and scalar-broadcast mux for one read port
module reg_file_read_port
  import reg_file_pkg::*;
(
  input  sel_t                  sel_i,
  input  vec_t  [REG_QTY-1:0]   vec_regs_i,
  input  lane_t [REG_QTY-1:0]   sc_regs_i,
  output vec_t                  data_o
);
  region_e region;
  assign region = region_of(sel_i);
  assign data_o = region == REGION_VEC ? vec_regs_i[idx_t'(sel_i - VEC_BASE)]
                : region == REGION_SC  ? {VEC_SIZE{sc_regs_i[idx_t'(sel_i - SC_BASE)]}}
                : '0;
endmodule

// File: rtl/reg_file.sv
// reg_file: unified vector/scalar register file, two combinational reads, one sync write
module reg_file
  import reg_file_pkg::*;
(
  input logic        clk,
  input logic        reset,
  reg_file_if.slave  bus
);
  vec_t  [REG_QTY-1:0] vec_q, vec_d;
  lane_t [REG_QTY-1:0] sc_q, sc_d;
  region_e wr_region;
  assign wr_region = region_of(bus.regToWrite);
  // an enable only acts when it matches the address class, so at most one register changes
  always_comb begin
    vec_d = vec_q;
    sc_d = sc_q;
    if (bus.regWrEnVec && wr_region == REGION_VEC) vec_d[idx_t'(bus.regToWrite - VEC_BASE)] = bus.dataIn;
    if (bus.regWrEnSc && wr_region == REGION_SC) sc_d[idx_t'(bus.regToWrite - SC_BASE)] = bus.dataIn[0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      vec_q <= '0;
      sc_q <= '0;
    end else begin
      vec_q <= vec_d;
      sc_q <= sc_d;
    end
  end
  reg_file_read_port u_rd1 (.sel_i(bus.rSel1), .vec_regs_i(vec_q), .sc_regs_i(sc_q), .data_o(bus.operand1));
  reg_file_read_port u_rd2 (.sel_i(bus.rSel2), .vec_regs_i(vec_q), .sc_regs_i(sc_q), .data_o(bus.operand2));
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed vectors with hand-computed expectations for reg_file
module tb_reg_file;
  import reg_file_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  reg_file_if bus();
  reg_file dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(string tag, vec_t obs, vec_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic wr(logic sc, logic vec, sel_t a, vec_t d);
    @(negedge clk);
    bus.regWrEnSc = sc;
    bus.regWrEnVec = vec;
    bus.regToWrite = a;
    bus.dataIn = d;
    @(posedge clk);
    #1;
    bus.regWrEnSc = 1'b0;
    bus.regWrEnVec = 1'b0;
  endtask
  task automatic rd(sel_t a1, sel_t a2);
    bus.rSel1 = a1;
    bus.rSel2 = a2;
    #1;
  endtask
  task automatic chk_all_zero(string tag);
    for (int i = 0; i < 16; i++) begin
      rd(sel_t'(i), sel_t'(15 - i));
      chk($sformatf("%s_p1_a%0d", tag, i), bus.operand1, '0);
      chk($sformatf("%s_p2_a%0d", tag, 15 - i), bus.operand2, '0);
    end
  endtask
  initial begin
    bus.regWrEnSc = 1'b0;
    bus.regWrEnVec = 1'b0;
    bus.regToWrite = '0;
    bus.dataIn = '0;
    bus.rSel1 = '0;
    bus.rSel2 = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_all_zero("reset");
    wr(1'b1, 1'b0, 4'd4, 32'h0000_0004);
    rd(4'd4, 4'd1);
    chk("sc_wr_s0", bus.operand1, 32'h0404_0404);
    chk("sc_wr_v1", bus.operand2, 32'h0);
    rd(4'd0, 4'd1);
    chk("sc_wr_v0", bus.operand1, 32'h0);
    wr(1'b0, 1'b1, 4'd3, 32'hDEAD_BEEF);
    rd(4'd3, 4'd1);
    chk("vec_wr_v3", bus.operand1, 32'hDEAD_BEEF);
    chk("vec_wr_v1", bus.operand2, 32'h0);
    rd(4'd7, 4'd1);
    chk("vec_wr_s3", bus.operand1, 32'h0);
    rd(4'd4, 4'd3);
    chk("dual_p1", bus.operand1, 32'h0404_0404);
    chk("dual_p2", bus.operand2, 32'hDEAD_BEEF);
    rd(4'd12, 4'd8);
    chk("special_12", bus.operand1, 32'h0);
    chk("special_8", bus.operand2, 32'h0);
    wr(1'b1, 1'b1, 4'd12, 32'hFFFF_FFFF);
    rd(4'd12, 4'd15);
    chk("special_wr_12", bus.operand1, 32'h0);
    chk("special_wr_15", bus.operand2, 32'h0);
    rd(4'd3, 4'd4);
    chk("special_wr_v3", bus.operand1, 32'hDEAD_BEEF);
    chk("special_wr_s0", bus.operand2, 32'h0404_0404);
    rd(4'd0, 4'd7);
    chk("special_wr_v0", bus.operand1, 32'h0);
    chk("special_wr_s3", bus.operand2, 32'h0);
    wr(1'b0, 1'b1, 4'd5, 32'h1122_3344);
    rd(4'd5, 4'd1);
    chk("mis_vec_s1", bus.operand1, 32'h0);
    chk("mis_vec_v1", bus.operand2, 32'h0);
    wr(1'b1, 1'b0, 4'd2, 32'h1122_3344);
    rd(4'd2, 4'd6);
    chk("mis_sc_v2", bus.operand1, 32'h0);
    chk("mis_sc_s2", bus.operand2, 32'h0);
    wr(1'b1, 1'b1, 4'd6, 32'h0000_0077);
    rd(4'd6, 4'd6);
    chk("both_s2_p1", bus.operand1, 32'h7777_7777);
    chk("both_s2_p2", bus.operand2, 32'h7777_7777);
    rd(4'd2, 4'd5);
    chk("both_s2_v2", bus.operand1, 32'h0);
    chk("both_s2_s1", bus.operand2, 32'h0);
    wr(1'b1, 1'b1, 4'd1, 32'h1234_5678);
    rd(4'd1, 4'd5);
    chk("both_v1", bus.operand1, 32'h1234_5678);
    chk("both_v1_s1", bus.operand2, 32'h0);
    wr(1'b1, 1'b0, 4'd7, 32'hAABB_CC99);
    rd(4'd7, 4'd4);
    chk("sc_lane0_s3", bus.operand1, 32'h9999_9999);
    chk("sc_lane0_s0", bus.operand2, 32'h0404_0404);
    @(negedge clk);
    bus.regWrEnVec = 1'b1;
    bus.regToWrite = 4'd0;
    bus.dataIn = 32'h0102_0304;
    rd(4'd0, 4'd0);
    chk("nobypass_pre", bus.operand1, 32'h0);
    @(posedge clk);
    #1;
    bus.regWrEnVec = 1'b0;
    chk("nobypass_post_p1", bus.operand1, 32'h0102_0304);
    chk("nobypass_post_p2", bus.operand2, 32'h0102_0304);
    @(negedge clk);
    reset = 1'b1;
    bus.regWrEnVec = 1'b1;
    bus.regToWrite = 4'd3;
    bus.dataIn = 32'hCAFE_BABE;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.regWrEnVec = 1'b0;
    chk_all_zero("midreset");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
